// File: rtl/matvec_stream_engine.sv
// matvec_stream_engine: weight-stationary ROWSxCOLS matrix-vector engine, column-serial,
// with valid/ready vector input and result output, optional saturation and cross-vector accumulation.
module matvec_stream_engine #(
  parameter int DW = 8,
  parameter int ROWS = 12,
  parameter int COLS = 14,
  parameter int ROW_W = 4,
  parameter int COL_W = 4,
  parameter int ACC_W = 16,
  parameter logic SATURATE = 1'b1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     cfg_valid,
  input  logic [ROW_W+COL_W-1:0]   cfg_addr,
  input  logic signed [DW-1:0]     cfg_data,
  output logic                     cfg_err,
  input  logic                     err_clr,
  input  logic                     x_valid,
  output logic                     x_ready,
  input  logic                     x_accumulate,
  input  logic [COLS*DW-1:0]       x_vector_flat,
  output logic                     res_valid,
  input  logic                     res_ready,
  output logic [ROWS*ACC_W-1:0]    result_flat,
  output logic [1:0]               state
);
  typedef enum logic [1:0] {IDLE = 2'd0, COMPUTE = 2'd1, DONE = 2'd2} state_t;
  state_t cur, nxt;
  logic signed [DW-1:0] w [ROWS][COLS];
  logic signed [ACC_W-1:0] acc [ROWS];
  logic signed [ACC_W-1:0] acc_nxt [ROWS];
  logic [COLS*DW-1:0] xv;
  logic [COL_W-1:0] col;
  logic [ROW_W-1:0] wr_row;
  logic [COL_W-1:0] wr_col;
  logic in_range, wr_ok, wr_drop, accept, last;
  assign {wr_row, wr_col} = cfg_addr;
  assign in_range = (32'(wr_row) < ROWS) && (32'(wr_col) < COLS);
  assign wr_ok = cfg_valid && in_range && cur != COMPUTE;
  assign wr_drop = cfg_valid && !wr_ok;
  assign accept = cur == IDLE && x_valid;
  assign last = col == COL_W'(COLS - 1);
  assign x_ready = cur == IDLE;
  assign res_valid = cur == DONE;
  assign state = cur;
  always_comb begin
    nxt = cur;
    nxt = cur == IDLE ? (x_valid ? COMPUTE : IDLE) :
          cur == COMPUTE ? (last ? DONE : COMPUTE) :
          (res_ready ? IDLE : DONE);
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) cur <= IDLE;
    else cur <= nxt;
  // Sum is one bit wider than the accumulator so overflow shows as a sign-bit disagreement.
  for (genvar r = 0; r < ROWS; r++) begin : g_row
    logic signed [2*DW-1:0] prod;
    logic signed [ACC_W:0] sum;
    assign prod = w[r][col] * $signed(xv[col*DW +: DW]);
    assign sum = acc[r] + prod;
    assign acc_nxt[r] = (SATURATE && sum[ACC_W] != sum[ACC_W-1]) ?
                        {sum[ACC_W], {(ACC_W-1){~sum[ACC_W]}}} : sum[ACC_W-1:0];
    assign result_flat[r*ACC_W +: ACC_W] = acc[r];
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      col <= '0;
      xv <= '0;
      cfg_err <= 1'b0;
      for (int r = 0; r < ROWS; r++) begin
        acc[r] <= '0;
        for (int c = 0; c < COLS; c++) w[r][c] <= '0;
      end
    end else begin
      cfg_err <= wr_drop ? 1'b1 : err_clr ? 1'b0 : cfg_err;
      if (wr_ok) w[wr_row][wr_col] <= cfg_data;
      if (accept) begin
        xv <= x_vector_flat;
        col <= '0;
        if (!x_accumulate) for (int r = 0; r < ROWS; r++) acc[r] <= '0;
      end
      if (cur == COMPUTE) begin
        for (int r = 0; r < ROWS; r++) acc[r] <= acc_nxt[r];
        col <= last ? col : col + 1'b1;
      end
    end
endmodule
